// File: rtl/fp_serial_pkg.sv
// Shared state encodings and exponent helpers for the bit-serial FP add/sub.
package fp_serial_pkg;

  localparam logic [3:0] S_IDLE   = 4'd0;
  localparam logic [3:0] S_LOAD_A = 4'd1;
  localparam logic [3:0] S_LOAD_B = 4'd2;
  localparam logic [3:0] S_ALIGN  = 4'd3;
  localparam logic [3:0] S_ADD    = 4'd4;
  localparam logic [3:0] S_NORM   = 4'd5;
  localparam logic [3:0] S_ROUND  = 4'd6;
  localparam logic [3:0] S_OUT    = 4'd7;
  localparam logic [3:0] S_DONE   = 4'd8;

  function automatic int exp_bias(input int exp_w);
    return (1 << (exp_w - 1)) - 1;
  endfunction

  function automatic int exp_ones(input int exp_w);
    return (1 << exp_w) - 1;
  endfunction

endpackage

// File: rtl/fp_align_shift.sv
// Right shifter for the smaller significand; appends guard/round and folds
// every bit shifted past the sticky position into the sticky bit.
module fp_align_shift #(
  parameter int MAN_W  = 23,
  parameter int DIFF_W = 8
) (
  input  logic [MAN_W:0]    sig_i,
  input  logic [DIFF_W-1:0] diff_i,
  output logic [MAN_W+3:0]  sig_o
);
  localparam int SW = MAN_W + 4;

  logic [2*SW-1:0] wide;
  int              amt;

  always_comb begin
    amt = int'(diff_i);
    if (amt > SW) amt = SW;
    wide  = {sig_i, 3'b000, {SW{1'b0}}} >> amt;
    sig_o = wide[2*SW-1:SW] | {{(SW-1){1'b0}}, |wide[SW-1:0]};
  end

endmodule

// File: rtl/serial_fp_addsub.sv
// Bit-serial floating-point adder/subtractor: operands A then B in MSB-first,
// result out MSB-first with overflow/underflow flags and a done pulse.
//
// state  | meaning
// IDLE   | wait for go low, latch sub
// LOAD_A | shift W bits of A in
// LOAD_B | shift W bits of B in
// ALIGN  | order by magnitude, align smaller significand (inf shortcut to OUT)
// ADD    | add/subtract magnitudes, absorb carry-out
// NORM   | left-normalise one bit per cycle, flag underflow at exponent 1
// ROUND  | round to nearest even, detect overflow
// OUT    | shift W result bits out
// DONE   | one-cycle done pulse
module serial_fp_addsub
  import fp_serial_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic clk,
  input  logic reset,
  input  logic go,
  input  logic sub,
  input  logic inpab,
  output logic shift,
  output logic out_c,
  output logic over,
  output logic under,
  output logic done
);
  localparam int W     = 1 + EXP_W + MAN_W;
  localparam int CNT_W = $clog2(W + 1);
  localparam int SW    = MAN_W + 4;
  localparam int E_ONES_I = exp_ones(EXP_W);
  localparam logic [EXP_W:0]   E_MAX    = E_ONES_I[EXP_W:0];
  localparam logic [EXP_W-1:0] E_ONES   = E_MAX[EXP_W-1:0];
  localparam logic [EXP_W:0]   EXP_ONE  = {{EXP_W{1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(W - 1);

  logic [3:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [W-1:0]     a_q, a_d, b_q, b_d, res_q, res_d;
  logic             sub_q, sub_d, sign_q, sign_d, esub_q, esub_d;
  logic             over_q, over_d, under_q, under_d;
  logic [EXP_W:0]   exp_q, exp_d;
  logic [SW-1:0]    xsig_q, xsig_d, ysig_q, ysig_d;

  logic [EXP_W-1:0] a_exp, b_exp, x_exp, y_exp, exp_diff;
  logic [MAN_W-1:0] a_man, b_man;
  logic             a_sign, b_sign, a_zero, b_zero, a_inf, b_inf;
  logic             swap, x_sign, x_zero, y_zero, inf_sign;
  logic [MAN_W:0]   x_sig, y_sig;
  logic [SW-1:0]    y_aligned;
  logic [SW:0]      sum;
  logic             round_up, rzero;
  logic [MAN_W+1:0] rnd;
  logic [EXP_W:0]   rexp;
  logic [MAN_W-1:0] rman;

  // Zero operands have their mantissa flushed so magnitude order is exact.
  always_comb begin
    a_sign = a_q[W-1];
    b_sign = b_q[W-1] ^ sub_q;
    a_exp  = a_q[W-2:MAN_W];
    b_exp  = b_q[W-2:MAN_W];
    a_zero = (a_exp == {EXP_W{1'b0}});
    b_zero = (b_exp == {EXP_W{1'b0}});
    a_inf  = (a_exp == E_ONES);
    b_inf  = (b_exp == E_ONES);
    a_man  = a_zero ? {MAN_W{1'b0}} : a_q[MAN_W-1:0];
    b_man  = b_zero ? {MAN_W{1'b0}} : b_q[MAN_W-1:0];
    swap   = {b_exp, b_man} > {a_exp, a_man};
    x_sign = swap ? b_sign : a_sign;
    x_exp  = swap ? b_exp : a_exp;
    y_exp  = swap ? a_exp : b_exp;
    x_zero = swap ? b_zero : a_zero;
    y_zero = swap ? a_zero : b_zero;
    x_sig  = {~x_zero, swap ? b_man : a_man};
    y_sig  = {~y_zero, swap ? a_man : b_man};
    exp_diff = x_exp - y_exp;
    inf_sign = (a_inf & b_inf & (a_sign != b_sign)) ? 1'b0 : (a_inf ? a_sign : b_sign);
  end

  fp_align_shift #(.MAN_W(MAN_W), .DIFF_W(EXP_W)) u_align (
    .sig_i  (y_sig),
    .diff_i (exp_diff),
    .sig_o  (y_aligned)
  );

  always_comb begin
    sum      = esub_q ? ({1'b0, xsig_q} - {1'b0, ysig_q}) : ({1'b0, xsig_q} + {1'b0, ysig_q});
    round_up = xsig_q[2] & (xsig_q[1] | xsig_q[0] | xsig_q[3]);
    rnd      = {1'b0, xsig_q[SW-1:3]} + {{(MAN_W+1){1'b0}}, round_up};
    rexp     = exp_q + {{EXP_W{1'b0}}, rnd[MAN_W+1]};
    rman     = rnd[MAN_W+1] ? {MAN_W{1'b0}} : rnd[MAN_W-1:0];
    rzero    = ~(rnd[MAN_W+1] | rnd[MAN_W]);
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    sub_d   = sub_q;
    sign_d  = sign_q;
    esub_d  = esub_q;
    over_d  = over_q;
    under_d = under_q;
    exp_d   = exp_q;
    xsig_d  = xsig_q;
    ysig_d  = ysig_q;
    case (state_q)
      S_IDLE: if (!go) begin
        state_d = S_LOAD_A;
        sub_d   = sub;
        cnt_d   = CNT_LAST;
        over_d  = 1'b0;
        under_d = 1'b0;
      end
      S_LOAD_A: begin
        a_d = {a_q[W-2:0], inpab};
        if (cnt_q == '0) begin
          state_d = S_LOAD_B;
          cnt_d   = CNT_LAST;
        end else cnt_d = cnt_q - 1'b1;
      end
      S_LOAD_B: begin
        b_d = {b_q[W-2:0], inpab};
        if (cnt_q == '0) state_d = S_ALIGN;
        else cnt_d = cnt_q - 1'b1;
      end
      S_ALIGN: if (a_inf | b_inf) begin
        over_d  = 1'b1;
        res_d   = {inf_sign, E_ONES, {MAN_W{1'b0}}};
        cnt_d   = CNT_LAST;
        state_d = S_OUT;
      end else begin
        sign_d  = x_sign;
        esub_d  = a_sign ^ b_sign;
        exp_d   = {1'b0, x_exp};
        xsig_d  = {x_sig, 3'b000};
        ysig_d  = y_aligned;
        state_d = S_ADD;
      end
      S_ADD: begin
        if (sum == '0) begin
          xsig_d  = '0;
          sign_d  = esub_q ? 1'b0 : sign_q;
          state_d = S_ROUND;
        end else if (sum[SW]) begin
          xsig_d  = sum[SW:1] | {{(SW-1){1'b0}}, sum[0]};
          exp_d   = exp_q + EXP_ONE;
          state_d = S_ROUND;
        end else begin
          xsig_d  = sum[SW-1:0];
          state_d = sum[SW-1] ? S_ROUND : S_NORM;
        end
      end
      S_NORM: if (exp_q > EXP_ONE) begin
        xsig_d = {xsig_q[SW-2:0], 1'b0};
        exp_d  = exp_q - EXP_ONE;
        if (xsig_q[SW-2]) state_d = S_ROUND;
      end else begin
        under_d = 1'b1;
        res_d   = {sign_q, {(W-1){1'b0}}};
        cnt_d   = CNT_LAST;
        state_d = S_OUT;
      end
      S_ROUND: begin
        cnt_d   = CNT_LAST;
        state_d = S_OUT;
        if (rzero) res_d = {sign_q, {(W-1){1'b0}}};
        else if (rexp >= E_MAX) begin
          over_d = 1'b1;
          res_d  = {sign_q, E_ONES, {MAN_W{1'b0}}};
        end else res_d = {sign_q, rexp[EXP_W-1:0], rman};
      end
      S_OUT: begin
        res_d = {res_q[W-2:0], 1'b0};
        if (cnt_q == '0) state_d = S_DONE;
        else cnt_d = cnt_q - 1'b1;
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      sub_q   <= 1'b0;
      sign_q  <= 1'b0;
      esub_q  <= 1'b0;
      over_q  <= 1'b0;
      under_q <= 1'b0;
      exp_q   <= '0;
      xsig_q  <= '0;
      ysig_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      sub_q   <= sub_d;
      sign_q  <= sign_d;
      esub_q  <= esub_d;
      over_q  <= over_d;
      under_q <= under_d;
      exp_q   <= exp_d;
      xsig_q  <= xsig_d;
      ysig_q  <= ysig_d;
    end
  end

  assign shift = (state_q == S_OUT);
  assign out_c = shift & res_q[W-1];
  assign done  = (state_q == S_DONE);
  assign over  = over_q;
  assign under = under_q;

endmodule

// File: tb/tb_serial_fp_addsub.sv
// Bench for serial_fp_addsub: FP32 and 5/10 instances, directed cases, reset
// aborts and random operands against a real-arithmetic reference model.
module tb_serial_fp_addsub;

  logic clk = 1'b0;
  logic reset;
  logic go32, sub32, inp32, shift32, outc32, over32, under32, done32;
  logic go16, sub16, inp16, shift16, outc16, over16, under16, done16;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  serial_fp_addsub u_dut32 (
    .clk(clk), .reset(reset), .go(go32), .sub(sub32), .inpab(inp32),
    .shift(shift32), .out_c(outc32), .over(over32), .under(under32), .done(done32)
  );

  serial_fp_addsub #(.EXP_W(5), .MAN_W(10)) u_dut16 (
    .clk(clk), .reset(reset), .go(go16), .sub(sub16), .inpab(inp16),
    .shift(shift16), .out_c(outc16), .over(over16), .under(under16), .done(done16)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic real pow2(input int k);
    real r = 1.0;
    if (k >= 0) repeat (k) r = r * 2.0;
    else repeat (-k) r = r / 2.0;
    return r;
  endfunction

  // Exact real sum (operand spans are kept within double precision), then
  // rounded to the target format with ties-to-even and flush-to-zero.
  function automatic logic [31:0] ref_op(input int ew, input int mw, input logic [31:0] a,
                                         input logic [31:0] b, input bit s,
                                         output bit ov, output bit un);
    int bias = (1 << (ew - 1)) - 1;
    int emax = (1 << ew) - 1;
    logic [31:0] mmask = (32'd1 << mw) - 32'd1;
    int ea = int'((a >> mw) & 32'(emax));
    int eb = int'((b >> mw) & 32'(emax));
    int ma = int'(a & mmask);
    int mb = int'(b & mmask);
    bit sa = a[ew+mw];
    bit sb = b[ew+mw] ^ s;
    bit sg;
    real va, vb, v, m, frac, rem;
    longint fi;
    int e;
    ov = 1'b0;
    un = 1'b0;
    if (ea == emax || eb == emax) begin
      ov = 1'b1;
      if (ea == emax && eb == emax && sa != sb) sg = 1'b0;
      else sg = (ea == emax) ? sa : sb;
      return (32'(sg) << (ew + mw)) | (32'(emax) << mw);
    end
    va = (ea == 0) ? 0.0 : (1.0 + real'(ma) / pow2(mw)) * pow2(ea - bias);
    vb = (eb == 0) ? 0.0 : (1.0 + real'(mb) / pow2(mw)) * pow2(eb - bias);
    if (sa) va = -va;
    if (sb) vb = -vb;
    v = va + vb;
    if (v == 0.0) begin
      sg = (ea == 0 && eb == 0 && sa == sb) ? sa : 1'b0;
      return 32'(sg) << (ew + mw);
    end
    sg = (v < 0.0);
    m  = sg ? -v : v;
    if (m < pow2(1 - bias)) begin
      un = 1'b1;
      return 32'(sg) << (ew + mw);
    end
    e = 0;
    while (m >= 2.0) begin m = m / 2.0; e++; end
    while (m < 1.0) begin m = m * 2.0; e--; end
    frac = (m - 1.0) * pow2(mw);
    fi   = longint'($floor(frac));
    rem  = frac - real'(fi);
    if (rem > 0.5 || (rem == 0.5 && (fi % 2) == 1)) fi++;
    if (fi == (longint'(1) << mw)) begin fi = 0; e++; end
    if (e + bias >= emax) begin
      ov = 1'b1;
      return (32'(sg) << (ew + mw)) | (32'(emax) << mw);
    end
    return (32'(sg) << (ew + mw)) | (32'(e + bias) << mw) | 32'(fi);
  endfunction

  task automatic drive(input int sel, input logic g, input logic s, input logic d);
    if (sel == 1) begin go16 = g; sub16 = s; inp16 = d; end
    else begin go32 = g; sub32 = s; inp32 = d; end
  endtask

  task automatic sample(input int sel, output logic sh, output logic oc, output logic ov,
                        output logic un, output logic dn);
    if (sel == 1) begin sh = shift16; oc = outc16; ov = over16; un = under16; dn = done16; end
    else begin sh = shift32; oc = outc32; ov = over32; un = under32; dn = done32; end
  endtask

  task automatic send_operands(input int sel, input logic [31:0] a, input logic [31:0] b,
                               input bit s, input int nb);
    int w = (sel == 1) ? 16 : 32;
    @(negedge clk);
    drive(sel, 1'b0, s, 1'b0);
    for (int i = 0; i < w; i++) begin
      @(negedge clk);
      drive(sel, 1'b1, s, a[w-1-i]);
    end
    for (int i = 0; i < nb; i++) begin
      @(negedge clk);
      drive(sel, 1'b1, s, b[w-1-i]);
    end
  endtask

  task automatic run_op(input string tag, input int sel, input logic [31:0] a,
                        input logic [31:0] b, input bit s, input logic [31:0] exp_r,
                        input bit exp_ov, input bit exp_un);
    int w = (sel == 1) ? 16 : 32;
    logic [31:0] res = '0;
    int nsh = 0, nd = 0;
    logic sh, oc, ov, un, dn;
    logic got_ov = 1'b0, got_un = 1'b0;
    send_operands(sel, a, b, s, w);
    for (int c = 0; c < 120; c++) begin
      @(negedge clk);
      sample(sel, sh, oc, ov, un, dn);
      if (sh) begin
        if (nsh == 0) begin got_ov = ov; got_un = un; end
        res = {res[30:0], oc};
        nsh++;
      end
      if (dn) nd++;
    end
    check({tag, "_res"}, res, exp_r);
    check({tag, "_over"}, 32'(got_ov), 32'(exp_ov));
    check({tag, "_under"}, 32'(got_un), 32'(exp_un));
    check({tag, "_shift_cycles"}, 32'(nsh), 32'(w));
    check({tag, "_done_pulses"}, 32'(nd), 32'd1);
  endtask

  typedef struct {
    int          sel;
    logic [31:0] a;
    logic [31:0] b;
    bit          s;
    logic [31:0] r;
    bit          ov;
    bit          un;
  } vec_t;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t dir[10] = '{
      '{0, 32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 1'b0, 1'b0},
      '{0, 32'h40400000, 32'h3F800000, 1'b1, 32'h40000000, 1'b0, 1'b0},
      '{0, 32'h00C00000, 32'h80800000, 1'b0, 32'h00000000, 1'b0, 1'b1},
      '{0, 32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 1'b1, 1'b0},
      '{0, 32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 1'b0, 1'b0},
      '{0, 32'h41200000, 32'hC1200000, 1'b0, 32'h00000000, 1'b0, 1'b0},
      '{0, 32'h7F800000, 32'h7F800000, 1'b1, 32'h7F800000, 1'b1, 1'b0},
      '{0, 32'hFF800000, 32'h3F800000, 1'b0, 32'hFF800000, 1'b1, 1'b0},
      '{1, 32'h00003C00, 32'h00003C00, 1'b0, 32'h00004000, 1'b0, 1'b0},
      '{1, 32'h00007BFF, 32'h00007BFF, 1'b0, 32'h00007C00, 1'b1, 1'b0}
    };
    logic [31:0] a, b, er;
    bit s, eov, eun;
    int ea, eb, base, r1, r2, nsh;

    reset = 1'b0;
    drive(0, 1'b1, 1'b0, 1'b0);
    drive(1, 1'b1, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    check("reset_outs32", {27'd0, shift32, outc32, over32, under32, done32}, 32'd0);
    check("reset_outs16", {27'd0, shift16, outc16, over16, under16, done16}, 32'd0);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    foreach (dir[i])
      run_op($sformatf("dir%0d", i), dir[i].sel, dir[i].a, dir[i].b, dir[i].s,
             dir[i].r, dir[i].ov, dir[i].un);

    // Abort while the result is streaming out of an overflowing operation.
    send_operands(0, 32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32);
    nsh = 0;
    for (int c = 0; c < 60 && !shift32; c++) @(negedge clk);
    check("pre_abort_shift", 32'(shift32), 32'd1);
    check("pre_abort_over", 32'(over32), 32'd1);
    reset = 1'b0;
    #1;
    check("abort_out_outs", {27'd0, shift32, outc32, over32, under32, done32}, 32'd0);
    @(negedge clk);
    reset = 1'b1;

    // Abort during B loading: nothing may be emitted afterwards.
    send_operands(0, 32'h41200000, 32'hC1200000, 1'b0, 10);
    reset = 1'b0;
    #1;
    check("abort_loadb_outs", {27'd0, shift32, outc32, over32, under32, done32}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (shift32 || done32) nsh++;
    end
    check("abort_no_partial", 32'(nsh), 32'd0);
    run_op("post_abort", 0, 32'h40400000, 32'h3F800000, 1'b1, 32'h40000000, 1'b0, 1'b0);

    for (int i = 0; i < 30; i++) begin
      r1 = $urandom_range(0, 19);
      ea = (r1 == 0) ? 0 : (r1 == 1) ? 255 : $urandom_range(1, 254);
      base = (ea == 0 || ea == 255) ? $urandom_range(1, 254) : ea;
      r2 = $urandom_range(0, 19);
      if (r2 == 0) eb = 0;
      else if (r2 == 1) eb = 255;
      else if (r2 < 5) eb = base;
      else begin
        eb = base + $urandom_range(0, 52) - 26;
        if (eb < 1) eb = 1;
        if (eb > 254) eb = 254;
      end
      a = {1'($urandom_range(0, 1)), 8'(ea), 23'($urandom)};
      if (r2 >= 2 && r2 < 5) b = {1'($urandom_range(0, 1)), 8'(eb), a[22:0] ^ 23'($urandom_range(0, 255))};
      else b = {1'($urandom_range(0, 1)), 8'(eb), 23'($urandom)};
      s = 1'($urandom_range(0, 1));
      er = ref_op(8, 23, a, b, s, eov, eun);
      run_op($sformatf("rnd32_%0d", i), 0, a, b, s, er, eov, eun);
    end

    for (int i = 0; i < 25; i++) begin
      a = 32'($urandom_range(0, 65535));
      b = 32'($urandom_range(0, 65535));
      s = 1'($urandom_range(0, 1));
      er = ref_op(5, 10, a, b, s, eov, eun);
      run_op($sformatf("rnd16_%0d", i), 1, a, b, s, er, eov, eun);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
